// File: rtl/cacheline_adapter.sv
// Cache line port (256b) to 4-beat 64b burst memory responder.
// Define CACHELINE_ADAPTER_PREFETCH_EN to add the one-line prefetch buffer.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  input  logic         prefetch_req,
  input  logic [31:0]  prefetch_addr,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
    ,
    PF_REQ,
    PF_WAIT
`endif
  } state_t;

  state_t       state;
  state_t       next;
  logic [1:0]   cnt;
  logic [26:0]  addr;
  logic [255:0] line;
  logic [26:0]  dfp_line;
  logic         last_rd;
  logic         hit;
  logic [255:0] hit_line;
  logic         unused;

  assign dfp_line = dfp_addr[31:5];
  assign last_rd  = bmem_rvalid && (cnt == 2'd3);

`ifdef CACHELINE_ADAPTER_PREFETCH_EN
  logic         pf_pend;
  logic [26:0]  pf_addr;
  logic         buf_valid;
  logic [26:0]  buf_tag;
  logic [255:0] buf_line;
  logic [26:0]  pf_line;

  assign pf_line  = prefetch_addr[31:5];
  assign hit      = buf_valid && (buf_tag == dfp_line);
  assign hit_line = buf_line;
  assign unused   = ^{dfp_addr[4:0], prefetch_addr[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_pend   <= 1'b0;
      pf_addr   <= '0;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_line  <= '0;
    end else begin
      if (state == IDLE && dfp_write) begin
        if (buf_tag == dfp_line) buf_valid <= 1'b0;
        if (pf_addr == dfp_line) pf_pend <= 1'b0;
      end
      if (state == IDLE && !dfp_write && !dfp_read && pf_pend)
        pf_pend <= 1'b0;
      if (state == PF_WAIT && last_rd) begin
        buf_valid <= 1'b1;
        buf_tag   <= addr;
        buf_line  <= {bmem_rdata, line[191:0]};
      end
      // A newer hint replaces the pending one; hints for the held line are dropped
      if (prefetch_req && !(buf_valid && buf_tag == pf_line)) begin
        pf_pend <= 1'b1;
        pf_addr <= pf_line;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_line = '0;
  assign unused   = ^{dfp_addr[4:0], prefetch_req, prefetch_addr};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    dfp_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (dfp_write)     next = WR;
        else if (dfp_read) next = hit ? RESP : RD_REQ;
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
        else if (pf_pend)  next = PF_REQ;
`endif
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = {addr, 5'd0};
        if (bmem_ready) next = RD_WAIT;
      end
      RD_WAIT: if (last_rd) next = RESP;
      WR: begin
        bmem_write = 1'b1;
        bmem_addr  = {addr, 5'd0};
        bmem_wdata = dfp_wdata[{cnt, 6'd0} +: 64];
        if (bmem_ready && cnt == 2'd3) next = RESP;
      end
      RESP: begin
        dfp_resp  = 1'b1;
        dfp_rdata = line;
        next      = IDLE;
      end
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
      PF_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = {addr, 5'd0};
        if (bmem_ready) next = PF_WAIT;
      end
      PF_WAIT: if (last_rd) next = IDLE;
`endif
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      addr <= '0;
      line <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_write || dfp_read) addr <= dfp_line;
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
          else if (pf_pend) addr <= pf_addr;
`endif
          if (!dfp_write && dfp_read && hit) line <= hit_line;
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line[{cnt, 6'd0} +: 64] <= bmem_rdata;
            cnt <= cnt + 2'd1;
          end
        end
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
        PF_WAIT: begin
          if (bmem_rvalid) begin
            line[{cnt, 6'd0} +: 64] <= bmem_rdata;
            cnt <= cnt + 2'd1;
          end
        end
`endif
        WR: if (bmem_ready) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench for cacheline_adapter with a line-level memory model.
// Build with CACHELINE_ADAPTER_PREFETCH_EN to exercise the prefetch buffer.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         prefetch_req;
  logic [31:0]  prefetch_addr;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .prefetch_req(prefetch_req), .prefetch_addr(prefetch_addr),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ref_mem: what the cache expects; bus_mem: what the burst side actually stored
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] bus_mem [logic [31:0]];

  int   ready_mode = 0;
  int   latency = 0;
  bit   gaps = 0;
  bit   noise = 0;
  bit   tog = 0;
  int   rd_cmds = 0;
  int   wr_beats = 0;
  int   rd_idx = 0;
  int   rd_wait = 0;
  int   wr_idx = 0;
  bit   rd_active = 0;
  logic [31:0] rd_line = '0;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] lnum(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic void touch(input logic [31:0] a);
    logic [255:0] v;
    if (!ref_mem.exists(lnum(a))) begin
      v = rand_line();
      ref_mem[lnum(a)] = v;
      bus_mem[lnum(a)] = v;
    end
  endfunction

  // Burst memory: inputs chosen half a cycle before the edge that consumes them
  initial begin : mem_model
    logic [255:0] mt;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        rd_active   = 0;
        wr_idx      = 0;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
      end else begin
        tog = !tog;
        case (ready_mode)
          0:       bmem_ready = 1'b1;
          1:       bmem_ready = tog;
          default: bmem_ready = 1'($urandom_range(1));
        endcase
        bmem_rvalid = 1'b0;
        bmem_rdata  = {$urandom, $urandom};
        if (rd_active) begin
          if (rd_wait > 0) rd_wait--;
          else if (!gaps || $urandom_range(1) == 1) begin
            mt = bus_mem[rd_line];
            bmem_rvalid = 1'b1;
            bmem_rdata  = mt[rd_idx*64 +: 64];
            rd_idx++;
            if (rd_idx == 4) rd_active = 0;
          end
        end else if (noise && $urandom_range(3) == 0) begin
          bmem_rvalid = 1'b1;
        end
        if (bmem_read && bmem_ready) begin
          touch(bmem_addr);
          rd_cmds++;
          rd_active = 1;
          rd_idx    = 0;
          rd_wait   = latency;
          rd_line   = lnum(bmem_addr);
        end
        if (bmem_write && bmem_ready) begin
          touch(bmem_addr);
          mt = bus_mem[lnum(bmem_addr)];
          mt[wr_idx*64 +: 64] = bmem_wdata;
          bus_mem[lnum(bmem_addr)] = mt;
          wr_idx = (wr_idx + 1) % 4;
          wr_beats++;
        end
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [255:0] wd, output logic [255:0] rdata,
                        output int cyc);
    @(negedge clk);
    touch(a);
    if (wr) ref_mem[lnum(a)] = wd;
    dfp_addr  = a;
    dfp_read  = rd;
    dfp_write = wr;
    dfp_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dfp_resp && cyc < 2000);
    rdata = dfp_rdata;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    tests++;
    if (dfp_resp !== 1'b1) begin
      fails++;
      $display("FAIL req_timeout addr=%h: dfp_resp=%b after %0d cycles, want 1", a, dfp_resp, cyc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl: resp/read/write=%b want 000", {dfp_resp, bmem_read, bmem_write});
    end
    tests++;
    if (bmem_addr !== 32'd0 || bmem_wdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_bmem: addr=%h wdata=%h want 0", bmem_addr, bmem_wdata);
    end
    tests++;
    if (dfp_rdata !== 256'd0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 0", dfp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    logic [255:0] exp, got;
    int cyc, c0;
    ready_mode = 0; latency = 5; gaps = 0; noise = 1;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    ref_mem[32'h1040] = exp;
    bus_mem[32'h1040] = exp;
    c0 = rd_cmds;
    do_req(1, 0, 32'h0000_1040, '0, got, cyc);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL read_basic_data: got %h want %h", got, exp);
    end
    tests++;
    if (rd_cmds - c0 !== 1) begin
      fails++;
      $display("FAIL read_basic_cmds: got %0d bmem_read want 1", rd_cmds - c0);
    end
    // request edge, command edge, latency idle edges, four beats
    tests++;
    if (cyc !== 6 + latency) begin
      fails++;
      $display("FAIL read_basic_latency: got %0d cycles want %0d", cyc, 6 + latency);
    end
  endtask

  task automatic test_write_toggle();
    logic [255:0] wd, got;
    int cyc, c0, w0;
    ready_mode = 1; noise = 0;
    wd = rand_line();
    c0 = rd_cmds; w0 = wr_beats;
    do_req(0, 1, 32'h0000_2000, wd, got, cyc);
    tests++;
    if (bus_mem[32'h2000] !== wd) begin
      fails++;
      $display("FAIL write_toggle_mem: got %h want %h", bus_mem[32'h2000], wd);
    end
    tests++;
    if (wr_beats - w0 !== 4 || rd_cmds !== c0) begin
      fails++;
      $display("FAIL write_toggle_beats: beats=%0d reads=%0d want 4 and 0", wr_beats - w0, rd_cmds - c0);
    end
  endtask

  task automatic test_write_latency();
    logic [255:0] wd, got;
    int cyc;
    ready_mode = 0;
    wd = rand_line();
    do_req(0, 1, 32'h0000_2417, wd, got, cyc);
    tests++;
    if (cyc !== 5) begin
      fails++;
      $display("FAIL write_latency: got %0d cycles want 5", cyc);
    end
    tests++;
    if (bus_mem[32'h2400] !== wd) begin
      fails++;
      $display("FAIL write_latency_mem: got %h want %h", bus_mem[32'h2400], wd);
    end
  endtask

  task automatic test_read_write_both();
    logic [255:0] wd;
    logic [31:0] a;
    int c0, w0, n;
    ready_mode = 2; latency = 1; gaps = 1; noise = 1;
    a  = 32'h0000_4000 + 32'($urandom_range(0, 31));
    wd = rand_line();
    @(negedge clk);
    touch(a);
    ref_mem[lnum(a)] = wd;
    c0 = rd_cmds; w0 = wr_beats;
    dfp_addr = a; dfp_wdata = wd; dfp_read = 1'b1; dfp_write = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dfp_resp && n < 500);
    tests++;
    if (dfp_resp !== 1'b1 || rd_cmds !== c0 || wr_beats - w0 !== 4) begin
      fails++;
      $display("FAIL both_write_first: resp=%b reads=%0d beats=%0d want 1,0,4", dfp_resp, rd_cmds - c0, wr_beats - w0);
    end
    dfp_write = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!dfp_resp && n < 500);
    tests++;
    if (dfp_rdata !== wd || rd_cmds - c0 !== 1) begin
      fails++;
      $display("FAIL both_read_after: data=%h reads=%0d want %h,1", dfp_rdata, rd_cmds - c0, wd);
    end
    dfp_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [255:0] got, fresh;
    logic [31:0] a;
    int n, cyc, c0;
    ready_mode = 0; latency = 2; gaps = 0; noise = 0;
    a = 32'h0000_3000;
    touch(a);
    @(negedge clk);
    dfp_addr = a; dfp_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rd_active && rd_idx == 2) && n < 200);
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL reset_mid_wait: beats=%0d after %0d cycles want 2", rd_idx, n);
    end
    rst = 1'b1;
    dfp_read = 1'b0;
    @(negedge clk);
    tests++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000 || bmem_addr !== 32'd0 ||
        bmem_wdata !== 64'd0 || dfp_rdata !== 256'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: ctrl=%b addr=%h wdata=%h want all 0",
               {dfp_resp, bmem_read, bmem_write}, bmem_addr, bmem_wdata);
    end
    rst = 1'b0;
    fresh = rand_line();
    ref_mem[a] = fresh;
    bus_mem[a] = fresh;
    c0 = rd_cmds;
    do_req(1, 0, a, '0, got, cyc);
    tests++;
    if (got !== fresh || rd_cmds - c0 !== 1) begin
      fails++;
      $display("FAIL reset_mid_reread: data=%h reads=%0d want %h,1", got, rd_cmds - c0, fresh);
    end
  endtask

  task automatic test_prefetch();
    logic [255:0] got, wd;
    int n, cyc, c0;
    ready_mode = 0; latency = 3; gaps = 1; noise = 1;
    touch(32'h0000_1060);
    c0 = rd_cmds;
    @(negedge clk);
    prefetch_req = 1'b1; prefetch_addr = 32'h0000_1068;
    @(negedge clk);
    prefetch_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (n < 60);
`ifdef CACHELINE_ADAPTER_PREFETCH_EN
    tests++;
    if (rd_cmds - c0 !== 1 || rd_active) begin
      fails++;
      $display("FAIL pf_fill: reads=%0d active=%b want 1,0", rd_cmds - c0, rd_active);
    end
    c0 = rd_cmds;
    do_req(1, 0, 32'h0000_1060, '0, got, cyc);
    tests++;
    if (cyc !== 1 || rd_cmds !== c0) begin
      fails++;
      $display("FAIL pf_hit: cycles=%0d reads=%0d want 1,0", cyc, rd_cmds - c0);
    end
    tests++;
    if (got !== ref_mem[32'h1060]) begin
      fails++;
      $display("FAIL pf_hit_data: got %h want %h", got, ref_mem[32'h1060]);
    end
    wd = rand_line();
    do_req(0, 1, 32'h0000_1060, wd, got, cyc);
    c0 = rd_cmds;
    do_req(1, 0, 32'h0000_1060, '0, got, cyc);
    tests++;
    if (got !== wd || rd_cmds - c0 !== 1) begin
      fails++;
      $display("FAIL pf_invalidate: data=%h reads=%0d want %h,1", got, rd_cmds - c0, wd);
    end
`else
    tests++;
    if (rd_cmds !== c0) begin
      fails++;
      $display("FAIL pf_ignored: reads=%0d want 0", rd_cmds - c0);
    end
    do_req(1, 0, 32'h0000_1060, '0, got, cyc);
    tests++;
    if (got !== ref_mem[32'h1060] || rd_cmds - c0 !== 1) begin
      fails++;
      $display("FAIL pf_off_read: data=%h reads=%0d want %h,1", got, rd_cmds - c0, ref_mem[32'h1060]);
    end
    wd = '0;
`endif
  endtask

  task automatic test_random();
    logic [255:0] got, wd;
    logic [31:0] a;
    int cyc, c0;
    for (int i = 0; i < 40; i++) begin
      ready_mode = $urandom_range(0, 2);
      latency    = $urandom_range(0, 4);
      gaps       = 1'($urandom_range(1));
      noise      = 1'($urandom_range(1));
      a = 32'h0000_8000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
      if ($urandom_range(1) == 1) begin
        wd = rand_line();
        do_req(0, 1, a, wd, got, cyc);
        tests++;
        if (bus_mem[lnum(a)] !== wd) begin
          fails++;
          $display("FAIL rand_write[%0d] addr=%h: got %h want %h", i, a, bus_mem[lnum(a)], wd);
        end
      end else begin
        c0 = rd_cmds;
        do_req(1, 0, a, '0, got, cyc);
        tests++;
        if (got !== ref_mem[lnum(a)] || rd_cmds - c0 !== 1) begin
          fails++;
          $display("FAIL rand_read[%0d] addr=%h: got %h reads=%0d want %h,1", i, a, got, rd_cmds - c0, ref_mem[lnum(a)]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    prefetch_req = 1'b0; prefetch_addr = '0;
    test_reset();
    test_read_basic();
    test_write_toggle();
    test_write_latency();
    test_read_write_both();
    test_reset_mid();
    test_random();
    test_prefetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
